// File: rtl/game_pkg.sv
// Shared definitions for the level sequencer: tile codes, map geometry,
// ROM addressing helpers and the sequencer state encoding.
package game_pkg;

    localparam int unsigned TILES     = 150;
    localparam int unsigned TILE_W    = 4;
    localparam int unsigned MAP_W     = TILES * TILE_W;
    localparam int unsigned MAP_IDX_W = $clog2(MAP_W);
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned LEVEL_W   = 2;
    localparam int unsigned ITEMS_W   = 8;

    localparam logic [TILE_W-1:0] BLANK   = 4'd0;
    localparam logic [TILE_W-1:0] WALL    = 4'd1;
    localparam logic [TILE_W-1:0] COIN    = 4'd2;
    localparam logic [TILE_W-1:0] POWERUP = 4'd3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StPlay  = 3'd2,
        StClear = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Collectable tiles are the ones that count towards items_left.
    function automatic logic is_item(input logic [TILE_W-1:0] code);
        logic item;
        case (code)
            COIN, POWERUP: item = 1'b1;
            BLANK, WALL:   item = 1'b0;
            default:       item = 1'b0;
        endcase
        return item;
    endfunction

    function automatic logic [ADDR_W-1:0] level_base(input logic [LEVEL_W-1:0] lvl);
        return ADDR_W'(lvl) * ADDR_W'(TILES);
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Game-side bus of the level sequencer: control pulses, pickups, ROM port and
// the published level state.
interface level_sequencer_if;
    import game_pkg::*;

    logic                 start;
    logic                 pickup_valid;
    logic [IDX_W-1:0]     pickup_idx;
    logic [ADDR_W-1:0]    rom_addr;
    logic [TILE_W-1:0]    rom_data;
    logic [MAP_W-1:0]     map;
    logic                 map_valid;
    logic [LEVEL_W-1:0]   level;
    logic [ITEMS_W-1:0]   items_left;
    logic                 level_clear;
    logic                 game_done;

    modport master (
        output start, pickup_valid, pickup_idx, rom_data,
        input  rom_addr, map, map_valid, level, items_left, level_clear, game_done
    );

    modport slave (
        input  start, pickup_valid, pickup_idx, rom_data,
        output rom_addr, map, map_valid, level, items_left, level_clear, game_done
    );

endinterface

// File: rtl/delay_timer.sv
// Down-counter that times the CLEAR hold; done is high once CYCLES counting
// cycles have elapsed since load (CYCLES must be at least 1).
module delay_timer #(
    parameter int unsigned CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);
    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= RELOAD;
        end else if (count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: streams each level's tile map out of a synchronous ROM,
// tracks collected items and steps through the levels of a game.
module level_sequencer
    import game_pkg::*;
#(
    parameter int unsigned N_LEVELS   = 4,
    parameter int unsigned CLEAR_HOLD = 1200000
) (
    input logic              clk,
    input logic              rst,
    level_sequencer_if.slave bus
);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(N_LEVELS - 1);
    localparam logic [IDX_W-1:0]   LAST_STEP  = IDX_W'(TILES);
    localparam logic [IDX_W-1:0]   LAST_TILE  = IDX_W'(TILES - 1);

    state_e               r_state;
    state_e               w_state_next;
    logic [LEVEL_W-1:0]   r_level;
    logic [LEVEL_W-1:0]   w_level_next;
    logic [IDX_W-1:0]     r_tile;
    logic [ADDR_W-1:0]    r_rom_addr;
    logic [MAP_W-1:0]     r_map;
    logic [TILES-1:0]     r_seen;
    logic [ITEMS_W-1:0]   r_items;
    logic [ITEMS_W-1:0]   w_items_next;
    logic                 r_map_valid;
    logic                 r_level_clear;
    logic                 r_game_done;

    logic                 w_load_enter;
    logic                 w_timer_load;
    logic                 w_timer_done;
    logic                 w_in_load;
    logic                 w_load_last;
    logic                 w_capture;
    logic [IDX_W-1:0]     w_cap_idx;
    logic [MAP_IDX_W-1:0] w_cap_base;
    logic                 w_cap_item;
    logic                 w_pick_in_range;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [MAP_IDX_W-1:0] w_pick_base;
    logic [TILE_W-1:0]    w_pick_code;
    logic                 w_accept;

    // r_tile runs 0..TILES in LOAD; the tile addressed in step k is captured in step k+1.
    assign w_in_load   = (r_state == StLoad);
    assign w_load_last = w_in_load && (r_tile == LAST_STEP);
    assign w_capture   = w_in_load && (r_tile != '0);
    assign w_cap_idx   = r_tile - IDX_W'(1);
    assign w_cap_base  = {w_cap_idx, 2'b00};
    assign w_cap_item  = w_capture && is_item(bus.rom_data);

    assign w_pick_in_range = (bus.pickup_idx < LAST_STEP);
    assign w_pick_idx      = w_pick_in_range ? bus.pickup_idx : '0;
    assign w_pick_base     = {w_pick_idx, 2'b00};
    assign w_pick_code     = r_map[w_pick_base +: TILE_W];

    assign w_accept = (r_state == StPlay) && bus.pickup_valid && w_pick_in_range &&
                      is_item(w_pick_code) && !r_seen[w_pick_idx] && (r_items != '0);

    always_comb begin
        w_items_next = r_items;
        if (w_cap_item) begin
            w_items_next = r_items + ITEMS_W'(1);
        end else if (w_accept) begin
            w_items_next = r_items - ITEMS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_load_enter = 1'b0;
        w_timer_load = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_state_next = StLoad;
                    w_level_next = '0;
                    w_load_enter = 1'b1;
                end
            end
            StLoad: begin
                if (w_load_last) begin
                    if (w_items_next != '0) begin
                        w_state_next = StPlay;
                    end else begin
                        w_state_next = StClear;
                        w_timer_load = 1'b1;
                    end
                end
            end
            StPlay: begin
                if (w_items_next == '0) begin
                    w_state_next = StClear;
                    w_timer_load = 1'b1;
                end
            end
            StClear: begin
                if (w_timer_done) begin
                    if (r_level == LAST_LEVEL) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StLoad;
                        w_level_next = r_level + LEVEL_W'(1);
                        w_load_enter = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level       <= '0;
            r_tile        <= '0;
            r_rom_addr    <= '0;
            r_map         <= '0;
            r_seen        <= '0;
            r_items       <= '0;
            r_map_valid   <= 1'b0;
            r_level_clear <= 1'b0;
            r_game_done   <= 1'b0;
        end else begin
            r_level       <= w_level_next;
            r_items       <= w_items_next;
            r_map_valid   <= (w_state_next == StPlay) || (w_state_next == StClear);
            r_level_clear <= (w_state_next == StClear) && (r_state != StClear);
            r_game_done   <= (w_state_next == StDone);
            if (w_load_enter) begin
                r_tile     <= '0;
                r_rom_addr <= level_base(w_level_next);
                r_map      <= '0;
                r_seen     <= '0;
                r_items    <= '0;
            end else if (w_in_load) begin
                if (w_capture) begin
                    r_map[w_cap_base +: TILE_W] <= bus.rom_data;
                end
                if (!w_load_last) begin
                    r_tile <= r_tile + IDX_W'(1);
                end
                if (r_tile < LAST_TILE) begin
                    r_rom_addr <= r_rom_addr + ADDR_W'(1);
                end
            end
            if (w_accept) begin
                r_seen[w_pick_idx] <= 1'b1;
            end
        end
    end

    delay_timer #(
        .CYCLES (CLEAR_HOLD)
    ) u_clear_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_timer_load),
        .count (r_state == StClear),
        .done  (w_timer_done)
    );

    assign bus.rom_addr    = r_rom_addr;
    assign bus.map         = r_map;
    assign bus.map_valid   = r_map_valid;
    assign bus.level       = r_level;
    assign bus.items_left  = r_items;
    assign bus.level_clear = r_level_clear;
    assign bus.game_done   = r_game_done;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with a four-level ROM image and a
// four-cycle CLEAR hold; inputs driven and outputs sampled on the falling edge.
module tb_level_sequencer;
    import game_pkg::*;

    localparam int NT   = 150;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [3:0] rom [0:599];

    level_sequencer_if bus_if ();

    level_sequencer #(
        .N_LEVELS   (4),
        .CLEAR_HOLD (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Synchronous level ROM: data follows the address by one cycle.
    always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: time got=%0t want below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [599:0] exp_map(input int lvl);
        logic [599:0] m;
        m = '0;
        for (int t = 0; t < NT; t++) m[4*t +: 4] = rom[lvl*NT + t];
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic pickup(input logic [7:0] idx);
        bus_if.pickup_valid = 1'b1;
        bus_if.pickup_idx   = idx;
        @(negedge clk);
        bus_if.pickup_valid = 1'b0;
    endtask

    // Entered on the first LOAD cycle; returns on the first cycle after LOAD.
    task automatic run_load(input int lvl, input int exp_items, input logic [7:0] late_idx);
        logic [599:0] want_map;
        want_map = exp_map(lvl);
        n_cmp++;
        if (bus_if.map !== '0 || bus_if.items_left !== 8'd0) begin
            n_err++;
            $display("FAIL load_init lvl=%0d items_left got=%0d want=0, map zero got=%b want=1",
                     lvl, bus_if.items_left, bus_if.map === '0);
        end
        for (int k = 0; k <= NT; k++) begin
            n_cmp++;
            if (bus_if.map_valid !== 1'b0) begin
                n_err++;
                $display("FAIL load_map_valid lvl=%0d k=%0d got=%b want=0", lvl, k, bus_if.map_valid);
            end
            if (k < NT) begin
                n_cmp++;
                if (bus_if.rom_addr !== 11'(lvl*NT + k)) begin
                    n_err++;
                    $display("FAIL load_rom_addr lvl=%0d k=%0d got=%0d want=%0d",
                             lvl, k, bus_if.rom_addr, lvl*NT + k);
                end
            end
            if (k == NT) begin
                bus_if.pickup_valid = 1'b1;
                bus_if.pickup_idx   = late_idx;
            end
            @(negedge clk);
        end
        bus_if.pickup_valid = 1'b0;
        n_cmp++;
        if (bus_if.items_left !== 8'(exp_items)) begin
            n_err++;
            $display("FAIL load_items lvl=%0d got=%0d want=%0d", lvl, bus_if.items_left, exp_items);
        end
        n_cmp++;
        if (bus_if.map !== want_map) begin
            n_err++;
            $display("FAIL load_map lvl=%0d got=%h want=%h", lvl, bus_if.map, want_map);
        end
        n_cmp++;
        if (bus_if.level !== 2'(lvl)) begin
            n_err++;
            $display("FAIL load_level got=%0d want=%0d", bus_if.level, lvl);
        end
    endtask

    task automatic test_reset();
        bus_if.start = 1'b1;
        tick(2);
        n_cmp++;
        if ({bus_if.rom_addr, bus_if.map_valid, bus_if.level, bus_if.items_left,
             bus_if.level_clear, bus_if.game_done} !== '0 || bus_if.map !== '0) begin
            n_err++;
            $display("FAIL reset_values addr=%0d mv=%b lvl=%0d items=%0d lc=%b gd=%b want all 0",
                     bus_if.rom_addr, bus_if.map_valid, bus_if.level, bus_if.items_left,
                     bus_if.level_clear, bus_if.game_done);
        end
        bus_if.start = 1'b0;
        rst = 1'b1;
        tick(4);
        n_cmp++;
        if (bus_if.rom_addr !== 11'd0 || bus_if.map_valid !== 1'b0 || bus_if.game_done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset addr=%0d mv=%b gd=%b want 0/0/0",
                     bus_if.rom_addr, bus_if.map_valid, bus_if.game_done);
        end
    endtask

    task automatic test_load();
        pulse_start();
        run_load(0, 5, 8'd7);
        n_cmp++;
        if (bus_if.map_valid !== 1'b1 || bus_if.level_clear !== 1'b0) begin
            n_err++;
            $display("FAIL play_entry mv=%b lc=%b want 1/0", bus_if.map_valid, bus_if.level_clear);
        end
    endtask

    task automatic test_pickups();
        logic [7:0] idx_tab [5];
        logic [7:0] exp_tab [5];
        idx_tab = '{8'd7, 8'd7, 8'd10, 8'd50, 8'd200};
        exp_tab = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
        for (int i = 0; i < 5; i++) begin
            pickup(idx_tab[i]);
            n_cmp++;
            if (bus_if.items_left !== exp_tab[i]) begin
                n_err++;
                $display("FAIL pickup idx=%0d items_left got=%0d want=%0d",
                         idx_tab[i], bus_if.items_left, exp_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus_if.pickup_valid = 1'b1;
        bus_if.pickup_idx   = 8'd20;
        @(negedge clk);
        bus_if.pickup_idx   = 8'd0;
        n_cmp++;
        if (bus_if.items_left !== 8'd3) begin
            n_err++;
            $display("FAIL b2b_first items_left got=%0d want=3", bus_if.items_left);
        end
        @(negedge clk);
        bus_if.pickup_valid = 1'b0;
        n_cmp++;
        if (bus_if.items_left !== 8'd2) begin
            n_err++;
            $display("FAIL b2b_second items_left got=%0d want=2", bus_if.items_left);
        end
        pickup(8'd75);
        n_cmp++;
        if (bus_if.items_left !== 8'd1 || bus_if.map_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pickup_75 items_left got=%0d mv=%b want 1/1",
                     bus_if.items_left, bus_if.map_valid);
        end
    endtask

    task automatic test_progression();
        pickup(8'd149);
        n_cmp++;
        if (bus_if.level_clear !== 1'b1 || bus_if.items_left !== 8'd0 || bus_if.map_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clear_entry lc=%b items=%0d mv=%b want 1/0/1",
                     bus_if.level_clear, bus_if.items_left, bus_if.map_valid);
        end
        for (int c = 2; c <= HOLD; c++) begin
            tick(1);
            n_cmp++;
            if (bus_if.level_clear !== 1'b0 || bus_if.map_valid !== 1'b1 || bus_if.level !== 2'd0) begin
                n_err++;
                $display("FAIL clear_hold c=%0d lc=%b mv=%b lvl=%0d want 0/1/0",
                         c, bus_if.level_clear, bus_if.map_valid, bus_if.level);
            end
        end
        tick(1);
        n_cmp++;
        if (bus_if.level !== 2'd1 || bus_if.rom_addr !== 11'd150 || bus_if.map_valid !== 1'b0) begin
            n_err++;
            $display("FAIL next_level lvl=%0d addr=%0d mv=%b want 1/150/0",
                     bus_if.level, bus_if.rom_addr, bus_if.map_valid);
        end
    endtask

    task automatic test_empty_level();
        run_load(1, 0, 8'd5);
        n_cmp++;
        if (bus_if.level_clear !== 1'b1 || bus_if.map_valid !== 1'b1) begin
            n_err++;
            $display("FAIL empty_clear lc=%b mv=%b want 1/1", bus_if.level_clear, bus_if.map_valid);
        end
        tick(HOLD);
        n_cmp++;
        if (bus_if.level !== 2'd2 || bus_if.rom_addr !== 11'd300) begin
            n_err++;
            $display("FAIL empty_next lvl=%0d addr=%0d want 2/300", bus_if.level, bus_if.rom_addr);
        end
    endtask

    task automatic test_completion();
        run_load(2, 1, 8'd3);
        pulse_start();
        n_cmp++;
        if (bus_if.level !== 2'd2 || bus_if.items_left !== 8'd1 || bus_if.map_valid !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_play lvl=%0d items=%0d mv=%b want 2/1/1",
                     bus_if.level, bus_if.items_left, bus_if.map_valid);
        end
        pickup(8'd3);
        tick(HOLD);
        n_cmp++;
        if (bus_if.level !== 2'd3 || bus_if.rom_addr !== 11'd450) begin
            n_err++;
            $display("FAIL level3_load lvl=%0d addr=%0d want 3/450", bus_if.level, bus_if.rom_addr);
        end
        run_load(3, 1, 8'd149);
        pickup(8'd149);
        n_cmp++;
        if (bus_if.level_clear !== 1'b1) begin
            n_err++;
            $display("FAIL level3_clear lc got=%b want=1", bus_if.level_clear);
        end
        pulse_start();
        tick(HOLD - 1);
        n_cmp++;
        if (bus_if.game_done !== 1'b1 || bus_if.map_valid !== 1'b0 || bus_if.level !== 2'd3 ||
            bus_if.map !== exp_map(3)) begin
            n_err++;
            $display("FAIL done_state gd=%b mv=%b lvl=%0d map_ok=%b want 1/0/3/1",
                     bus_if.game_done, bus_if.map_valid, bus_if.level, bus_if.map === exp_map(3));
        end
        tick(2);
        n_cmp++;
        if (bus_if.game_done !== 1'b1) begin
            n_err++;
            $display("FAIL done_hold gd got=%b want=1", bus_if.game_done);
        end
        pulse_start();
        n_cmp++;
        if (bus_if.level !== 2'd0 || bus_if.rom_addr !== 11'd0 || bus_if.game_done !== 1'b0 ||
            bus_if.map !== '0) begin
            n_err++;
            $display("FAIL restart lvl=%0d addr=%0d gd=%b want 0/0/0",
                     bus_if.level, bus_if.rom_addr, bus_if.game_done);
        end
    endtask

    task automatic test_midload_reset();
        tick(70);
        n_cmp++;
        if (bus_if.rom_addr !== 11'd70) begin
            n_err++;
            $display("FAIL midload_addr got=%0d want=70", bus_if.rom_addr);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus_if.rom_addr, bus_if.map_valid, bus_if.level, bus_if.items_left,
             bus_if.level_clear, bus_if.game_done} !== '0 || bus_if.map !== '0) begin
            n_err++;
            $display("FAIL midload_reset addr=%0d mv=%b lvl=%0d items=%0d lc=%b gd=%b want all 0",
                     bus_if.rom_addr, bus_if.map_valid, bus_if.level, bus_if.items_left,
                     bus_if.level_clear, bus_if.game_done);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        n_cmp++;
        if (bus_if.rom_addr !== 11'd0 || bus_if.map_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_abort addr=%0d mv=%b want 0/0", bus_if.rom_addr, bus_if.map_valid);
        end
        pulse_start();
        run_load(0, 5, 8'd7);
        n_cmp++;
        if (bus_if.map_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reload_play mv got=%b want=1", bus_if.map_valid);
        end
    endtask

    initial begin
        rst                 = 1'b0;
        bus_if.start        = 1'b0;
        bus_if.pickup_valid = 1'b0;
        bus_if.pickup_idx   = 8'd0;
        for (int a = 0; a < 600; a++) rom[a] = BLANK;
        rom[0]   = POWERUP; rom[7]   = COIN; rom[10]  = WALL; rom[11] = WALL;
        rom[12]  = WALL;    rom[20]  = COIN; rom[75]  = POWERUP; rom[149] = COIN;
        rom[155] = WALL;    rom[156] = WALL;
        rom[300] = WALL;    rom[303] = COIN;
        rom[598] = WALL;    rom[599] = POWERUP;

        test_reset();
        test_load();
        test_pickups();
        test_back_to_back();
        test_progression();
        test_empty_level();
        test_completion();
        test_midload_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameters SHALL be: N_LEVELS, default 4, number of levels held in the level ROM; CLEAR_HOLD, default 1200000, number of cycles the CLEAR state is held.
REQ-002 clk  in  1  single system clock; all state changes occur on its rising edge.
REQ-003 rst  in  1  reset; asynchronous and active-low.
REQ-004 start  in  1  one-cycle pulse that starts a game at level 0.
REQ-005 pickup_valid  in  1  one-cycle pulse meaning a hero has collected a tile.
REQ-006 pickup_idx  in  8  tile index of the collected tile (x + y*15, range 0..149).
REQ-007 rom_addr  out  11  level ROM address, equal to level*150 + tile.
REQ-008 rom_data  in  4  tile code returned by the synchronous ROM one cycle after rom_addr.
REQ-009 map  out  600  tile map; tile t occupies bits [4t+3:4t].
REQ-010 map_valid  out  1  high only in PLAY and CLEAR.
REQ-011 level  out  2  current level index.
REQ-012 items_left  out  8  number of uncollected COIN and POWERUP tiles.
REQ-013 level_clear  out  1  one-cycle pulse on entry to CLEAR.
REQ-014 game_done  out  1  high while in DONE.

Function
REQ-015 The state machine SHALL have the states IDLE, LOAD, PLAY, CLEAR and DONE.
REQ-016 IDLE: on start, set level to 0 and go to LOAD; all other inputs are ignored.
REQ-017 LOAD, first cycle: clear map to all zeros (BLANK), items_left and the seen mask; rom_addr = level*150.
REQ-018 LOAD addressing: rom_addr SHALL step through tiles 0..149, one per cycle.
REQ-019 LOAD capture: rom_data for tile t SHALL be written into the map slot for tile t in the cycle after tile t is addressed.
REQ-020 LOAD counting: each captured tile coded COIN (2) or POWERUP (3) increments items_left.
REQ-021 LOAD duration SHALL be exactly 151 cycles.
REQ-022 LOAD exit: go to PLAY if items_left > 0, otherwise go directly to CLEAR.
REQ-023 PLAY: a pickup is accepted when pickup_valid=1, the map slot at pickup_idx holds COIN or POWERUP, and that index is not yet set in the 150-bit seen mask.
REQ-024 An accepted pickup SHALL set the seen bit and decrement items_left on the next edge.
REQ-025 Pickups are ignored when they are duplicates, address BLANK/WALL tiles, have pickup_idx ≥ 150, or arrive outside PLAY.
REQ-026 items_left SHALL never wrap below 0.
REQ-027 When items_left reaches 0 in PLAY, the next state SHALL be CLEAR.
REQ-028 CLEAR: level_clear pulses on the entry cycle; the state is held for CLEAR_HOLD cycles.
REQ-029 CLEAR exit: if level = N_LEVELS-1 go to DONE; otherwise increment level and go to LOAD.
REQ-030 DONE: game_done=1 and map is retained; start returns the block to LOAD with level 0.
REQ-031 start SHALL be ignored in LOAD, PLAY and CLEAR.
REQ-032 A pickup_valid coinciding with the last LOAD cycle SHALL be ignored.

Reset
REQ-033 While rst=0: state=IDLE, map=0, map_valid=0, level=0, items_left=0, level_clear=0, game_done=0, rom_addr=0, seen mask=0, hold counter=0.
REQ-034 Reset asserted mid-LOAD or mid-CLEAR SHALL abort immediately to the REQ-033 values; no partial map persists.
REQ-035 The block SHALL leave IDLE only on a start pulse received after reset is released.

Structure
REQ-036 The tile codes (BLANK=0, WALL=1, COIN=2, POWERUP=3), the constant TILES=150 and the state encodings SHALL live in the shared package game_pkg.
REQ-037 The CLEAR hold counter SHALL be a sub-module delay_timer (inputs: load, count; output: done).
REQ-038 All other logic SHALL be in one module.
REQ-039 All outputs SHALL be registered.

Verification
REQ-040 The bench SHALL run with CLEAR_HOLD=4 and a ROM model; it SHALL check map[599:0] against the ROM image and map_valid=0 throughout LOAD.
REQ-041 Load: level 0 with 3 COIN and 2 POWERUP -> start -> PLAY entered 152 cycles later, items_left=5.
REQ-042 Pickups: on the level 0 map of REQ-041, pickup_idx=7 (COIN) issued twice -> items_left=4 (duplicate ignored); pickup of a WALL index -> unchanged.
REQ-043 Progression: collect all 5 -> level_clear pulse, 4 hold cycles, level=1, LOAD restarts at rom_addr=150.
REQ-044 Empty level: level 1 with 0 items -> LOAD → CLEAR directly, level_clear pulses, then level=2.
REQ-045 Completion: clear level 3 -> DONE, game_done=1; start -> level=0, LOAD restarts at rom_addr=0.
REQ-046 Mid-load reset: rst low at LOAD cycle 70 -> all outputs at REQ-033 values; a subsequent start reloads level 0 completely.
